// File: rtl/div_seq_n.sv
// div_seq_n: parametrised multi-cycle restoring divider (signed/unsigned).
//
// Optional fast path: define DIV_SEQ_N_BYPASS_EN to skip the iteration loop
// when divor==0, divor==1 or |dived| < |divor| (never for signed overflow).
// With the macro undefined every operation takes WIDTH+1 cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      request, sampled only while ready=1
//   is_signed  1 = two's-complement operation, sampled with start
//   dived      dividend, sampled with start
//   divor      divisor, sampled with start
//   ready      1 while idle
//   done       single-cycle pulse when quoti/remai/dz are updated
//   quoti      quotient, held until the next done
//   remai      remainder, held until the next done
//   dz         divide-by-zero flag for the last result
`timescale 1ns / 1ps

module div_seq_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dived,
  input  logic [WIDTH-1:0] divor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quoti,
  output logic [WIDTH-1:0] remai,
  output logic             dz
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] quo;      // dividend shifts out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] dvd_raw;  // original dividend, returned as remainder on divide-by-zero
  logic             qneg;
  logic             rneg;
  logic             dz_pend;
  logic             ovf;

  logic [WIDTH-1:0] dived_mag;
  logic [WIDTH-1:0] divor_mag;
  logic             ovf_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1) {1'b0}}};

  always_comb begin
    dived_mag = (is_signed && dived[WIDTH-1]) ? -dived : dived;
    divor_mag = (is_signed && divor[WIDTH-1]) ? -divor : divor;
    ovf_in    = is_signed && (dived == MinNeg) && (&divor);
    rem_sh    = {rem, quo[WIDTH-1]};
    // One extra guard bit so the borrow is exact even when rem_sh >= 2^WIDTH.
    diff      = {1'b0, rem_sh} - {2'b00, dvs};
    ge        = ~diff[WIDTH+1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      dz_pend <= 1'b0;
      ovf     <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      quoti   <= '0;
      remai   <= '0;
      dz      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            rem     <= '0;
            quo     <= dived_mag;
            dvs     <= divor_mag;
            dvd_raw <= dived;
            // Unsigned mode ignores the operand sign bits entirely.
            qneg    <= is_signed & (dived[WIDTH-1] ^ divor[WIDTH-1]);
            rneg    <= is_signed & dived[WIDTH-1];
            dz_pend <= (divor == '0);
            ovf     <= ovf_in;
            cnt     <= '0;
            ready   <= 1'b0;
`ifdef DIV_SEQ_N_BYPASS_EN
            if (!ovf_in && ((divor == '0) || (divor == WIDTH'(1)) || (dived_mag < divor_mag))) begin
              state <= StFix;
              if (divor == WIDTH'(1)) begin
                quo <= dived_mag;
                rem <= '0;
              end else if (divor != '0) begin
                quo <= '0;
                rem <= dived_mag;
              end
            end else begin
              state <= StCalc;
            end
`else
            state <= StCalc;
`endif
          end
        end

        StCalc: begin
          if (ge) begin
            rem <= diff[WIDTH-1:0];
          end else begin
            rem <= rem_sh[WIDTH-1:0];
          end
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= StFix;
          end
        end

        StFix: begin
          if (dz_pend) begin
            quoti <= '1;
            remai <= dvd_raw;
            dz    <= 1'b1;
          end else if (ovf) begin
            quoti <= MinNeg;
            remai <= '0;
            dz    <= 1'b0;
          end else begin
            quoti <= qneg ? -quo : quo;
            remai <= rneg ? -rem : rem;
            dz    <= 1'b0;
          end
          done  <= 1'b1;
          state <= StDone;
        end

        StDone: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= StIdle;
        end

        default: begin
          state <= StIdle;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_n.sv
// Testbench for div_seq_n: a 32-bit and an 8-bit instance driven with directed
// and random operations, checked against an arithmetic reference model.
`timescale 1ns / 1ps

module tb_div_seq_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, s32, rdy32, done32, dz32;
  logic [31:0] a32, b32, q32, r32;
  logic        start8, s8, rdy8, done8, dz8;
  logic [7:0]  a8, b8, q8, r8;

  int tests = 0;
  int fails = 0;

  div_seq_n #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .start(start32), .is_signed(s32), .dived(a32), .divor(b32),
    .ready(rdy32), .done(done32), .quoti(q32), .remai(r32), .dz(dz32)
  );

  div_seq_n #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(s8), .dived(a8), .divor(b8),
    .ready(rdy8), .done(done8), .quoti(q8), .remai(r8), .dz(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic f_rdy(input int w);
    return (w == 8) ? rdy8 : rdy32;
  endfunction
  function automatic logic f_done(input int w);
    return (w == 8) ? done8 : done32;
  endfunction
  function automatic logic [31:0] f_q(input int w);
    return (w == 8) ? {24'd0, q8} : q32;
  endfunction
  function automatic logic [31:0] f_r(input int w);
    return (w == 8) ? {24'd0, r8} : r32;
  endfunction
  function automatic logic f_dz(input int w);
    return (w == 8) ? dz8 : dz32;
  endfunction

  task automatic set_in(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    if (w == 8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
    end else begin
      start32 = st; a32 = a; b32 = b; s32 = s;
    end
  endtask

  // Reference: plain integer division on sign-interpreted operands.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int lat);
    logic [63:0] mask, ua, ub;
    longint      sa, sb, mn, ma, mb;
    bit          ov;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (s && ua[w-1]) sa = sa - (longint'(1) << w);
    if (s && ub[w-1]) sb = sb - (longint'(1) << w);
    mn = -(longint'(1) << (w - 1));
    ov = s && (sa == mn) && (sb == -1);
    z = 1'b0;
    if (sb == 0) begin
      q = 32'(mask);
      r = 32'(ua);
      z = 1'b1;
    end else if (ov) begin
      q = 32'(ua);
      r = 32'd0;
    end else begin
      q = 32'(sa / sb) & 32'(mask);
      r = 32'(sa % sb) & 32'(mask);
    end
    lat = w + 1;
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
`ifdef DIV_SEQ_N_BYPASS_EN
    if (!ov && ((sb == 0) || (ub == 64'd1) || (ma < mb))) lat = 1;
`else
    if (ma < 0 || mb < 0) lat = 0;  // unreachable: magnitudes are non-negative
`endif
  endtask

  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inject);
    logic [31:0] eq, er;
    logic        ez;
    int          elat, lat;
    bit          seen;
    string       tag;
    model(w, a, b, s, eq, er, ez, elat);
    tag = $sformatf("w%0d %h/%h s%0d", w, a, b, s);
    @(negedge clk);
    lat = 0;
    while (!f_rdy(w) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " ready"}, 64'(f_rdy(w)), 64'd1);
    set_in(w, 1'b1, a, b, s);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, $urandom, $urandom, 1'($urandom));
    lat = 0;
    seen = 0;
    while (!seen && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
      if (f_done(w)) begin
        seen = 1;
      end else begin
        if (lat == 1) chk({tag, " busy"}, 64'(f_rdy(w)), 64'd0);
        set_in(w, 1'(inject > 0 && lat == inject), $urandom, $urandom, 1'($urandom));
      end
    end
    set_in(w, 1'b0, $urandom, $urandom, 1'($urandom));
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " quoti"}, 64'(f_q(w)), 64'(eq));
    chk({tag, " remai"}, 64'(f_r(w)), 64'(er));
    chk({tag, " dz"}, 64'(f_dz(w)), 64'(ez));
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, 64'(f_done(w)), 64'd0);
    chk({tag, " ready_back"}, 64'(f_rdy(w)), 64'd1);
  endtask

  task automatic rand_ops(input int w, input int n);
    logic [31:0] a, b, mn;
    logic        s;
    mn = 32'd1 << (w - 1);
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 4))
        0: b = $urandom_range(0, 20);
        1: b = (w == 8) ? {24'd0, b[7:0] >> $urandom_range(0, 7)} : b >> $urandom_range(0, 31);
        2: begin a = mn; b = 32'hFFFF_FFFF; end
        3: a = a >> $urandom_range(0, w - 1);
        default: ;
      endcase
      run_op(w, a, b, s, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int dcnt;

  initial begin
    rst = 1'b0;
    set_in(32, 1'b0, 32'd0, 32'd0, 1'b0);
    set_in(8, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int w = 8; w <= 32; w += 24) begin
      chk($sformatf("w%0d reset ready", w), 64'(f_rdy(w)), 64'd1);
      chk($sformatf("w%0d reset done", w), 64'(f_done(w)), 64'd0);
      chk($sformatf("w%0d reset quoti", w), 64'(f_q(w)), 64'd0);
      chk($sformatf("w%0d reset remai", w), 64'(f_r(w)), 64'd0);
      chk($sformatf("w%0d reset dz", w), 64'(f_dz(w)), 64'd0);
    end
    rst = 1'b1;

    run_op(32, 32'd100, 32'd7, 1'b0, 0);
    run_op(32, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32, 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32, 32'h8000_0000, 32'd0, 1'b1, 0);
    run_op(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    run_op(32, 32'd1000, 32'd3, 1'b0, 5);

    // Abort mid-operation with reset.
    @(negedge clk);
    set_in(32, 1'b1, 32'd50, 32'd3, 1'b0);
    @(posedge clk);
    #1;
    set_in(32, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort ready", 64'(rdy32), 64'd1);
    chk("abort done", 64'(done32), 64'd0);
    chk("abort quoti", 64'(q32), 64'd0);
    chk("abort remai", 64'(r32), 64'd0);
    chk("abort dz", 64'(dz32), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done32) dcnt++;
    end
    chk("abort no_done", 64'(dcnt), 64'd0);
    chk("abort idle_ready", 64'(rdy32), 64'd1);
    run_op(32, 32'hFFFF_FFFF, 32'h10, 1'b0, 0);

    rand_ops(32, 24);

    run_op(8, 32'd200, 32'd3, 1'b0, 0);
    run_op(8, 32'h80, 32'd3, 1'b1, 0);
    run_op(8, 32'h80, 32'hFF, 1'b1, 0);
    run_op(8, 32'h85, 32'd0, 1'b1, 0);
    rand_ops(8, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
